// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix-keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } kp_state_t;

  // Width of the key code for a ROWS x COLS matrix.
  function automatic int unsigned kp_cw(input int unsigned rows, input int unsigned cols);
    return $clog2(rows * cols);
  endfunction

  // Map a linear key index (row*COLS+col) to its printed legend.
  function automatic int unsigned kp_legend(input int unsigned idx, input int unsigned cw,
                                            input bit hex);
    if (hex) return (idx + 1) % (32'd1 << cw);
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchroniser for the asynchronous, active-low keypad rows.
module keypad_sync2 #(
  parameter int unsigned W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Resets to all ones so an idle (released) keypad is seen from the start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix-keypad scanner: column strobing, press/release debounce and a
// one-deep valid/ready output slot.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 4,
  parameter int unsigned SETTLE_CYCLES   = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned HEX_LEGEND      = 1,
  localparam int unsigned CW             = kp_cw(ROWS, COLS)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [ROWS-1:0] row_n,
  output logic [COLS-1:0] col_n,
  output logic [CW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            key_held,
  output logic            overflow
);

  localparam int unsigned KW = $clog2(COLS);
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned LW = $clog2(ROWS + 1);
  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [ROWS-1:0] row_s;
  logic [ROWS-1:0] row_lat;
  logic [RW-1:0]   row_sel;
  logic [KW-1:0]   col_k;
  logic [SW-1:0]   settle_cnt;
  logic [DW-1:0]   db_cnt;
  kp_state_t       state;

  logic [LW-1:0]   low_cnt;
  logic [RW-1:0]   low_idx;
  logic            one_low;
  logic            all_high;
  logic            rows_match;
  logic [KW-1:0]   col_next;
  logic            settled;
  logic            db_done;
  logic            accept;
  logic [CW-1:0]   acc_code;

  keypad_sync2 #(.W(ROWS)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (row_n),
    .q       (row_s)
  );

  // Row decode, column advance and accept decision from the synchronised rows.
  always_comb begin
    low_cnt = '0;
    low_idx = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (!row_s[r]) begin
        low_cnt = low_cnt + LW'(1);
        low_idx = RW'(r);
      end
    end
    one_low    = (low_cnt == LW'(1));
    all_high   = &row_s;
    rows_match = (row_s == row_lat);
    col_next   = (col_k == KW'(COLS - 1)) ? '0 : col_k + KW'(1);
    settled    = (settle_cnt == SW'(SETTLE_CYCLES - 1));
    db_done    = (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
    accept     = (state == PRESS_DB) && rows_match && db_done;
    acc_code   = CW'(kp_legend(32'(row_sel) * COLS + 32'(col_k), CW, HEX_LEGEND != 0));
  end

  // Scan/debounce FSM with registered column strobes and held flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SCAN;
      col_k      <= '0;
      col_n      <= ~(COLS'(1));
      settle_cnt <= '0;
      db_cnt     <= '0;
      row_lat    <= '1;
      row_sel    <= '0;
      key_held   <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (!settled) begin
            settle_cnt <= settle_cnt + SW'(1);
          end else if (one_low) begin
            row_lat <= row_s;
            row_sel <= low_idx;
            db_cnt  <= '0;
            state   <= PRESS_DB;
          end else begin
            col_k      <= col_next;
            col_n      <= ~(COLS'(1) << col_next);
            settle_cnt <= '0;
          end
        end
        PRESS_DB: begin
          if (!rows_match) begin
            state      <= SCAN;
            col_k      <= col_next;
            col_n      <= ~(COLS'(1) << col_next);
            settle_cnt <= '0;
          end else if (db_done) begin
            key_held <= 1'b1;
            state    <= HELD;
          end else begin
            db_cnt <= db_cnt + DW'(1);
          end
        end
        HELD: begin
          if (all_high) begin
            db_cnt <= '0;
            state  <= RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (!all_high) begin
            db_cnt <= '0;
            state  <= HELD;
          end else if (db_done) begin
            key_held   <= 1'b0;
            state      <= SCAN;
            col_k      <= col_next;
            col_n      <= ~(COLS'(1) << col_next);
            settle_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + DW'(1);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  // One-deep output slot; a handshake in the accept cycle frees room for the new code.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (accept) begin
        if (!key_valid || key_ready) begin
          key_code  <= acc_code;
          key_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: 4x4 matrix, SETTLE=4, DEBOUNCE=8, two legends.
module tb_keypad_scan_ctrl;

  localparam int unsigned S = 4;
  localparam int unsigned D = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        key_ready;
  logic [15:0] pressed;
  logic [3:0]  row_a, row_b, col_a, col_b, code_a, code_b;
  logic        valid_a, valid_b, held_a, held_b, ovf_a, ovf_b;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] rx_a[$];
  logic [3:0] rx_b[$];
  int         ovf_cnt = 0;
  int         stab_err = 0;
  logic       hold_pending = 1'b0;
  logic [3:0] hold_code = '0;

  always #5 clock = ~clock;

  keypad_scan_ctrl #(.ROWS(4), .COLS(4), .SETTLE_CYCLES(S), .DEBOUNCE_CYCLES(D), .HEX_LEGEND(1)) dut_hex (
    .clock(clock), .reset_n(reset_n), .row_n(row_a), .col_n(col_a), .key_code(code_a),
    .key_valid(valid_a), .key_ready(key_ready), .key_held(held_a), .overflow(ovf_a));

  keypad_scan_ctrl #(.ROWS(4), .COLS(4), .SETTLE_CYCLES(S), .DEBOUNCE_CYCLES(D), .HEX_LEGEND(0)) dut_idx (
    .clock(clock), .reset_n(reset_n), .row_n(row_b), .col_n(col_b), .key_code(code_b),
    .key_valid(valid_b), .key_ready(key_ready), .key_held(held_b), .overflow(ovf_b));

  // Keypad matrix model: a pressed switch shorts its row to its column strobe.
  always_comb begin
    row_a = '1;
    row_b = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c]) begin
          if (!col_a[c]) row_a[r] = 1'b0;
          if (!col_b[c]) row_b[r] = 1'b0;
        end
  end

  // Transaction monitor: sampled mid-cycle, records handshakes, overflow pulses, slot stability.
  always @(negedge clock) begin
    if (!reset_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending && (valid_a !== 1'b1 || code_a !== hold_code)) stab_err++;
      if (valid_a && key_ready) rx_a.push_back(code_a);
      if (valid_b && key_ready) rx_b.push_back(code_b);
      if (ovf_a) ovf_cnt++;
      hold_pending = valid_a && !key_ready;
      hold_code    = code_a;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] legend(input int r, input int c, input bit hex);
    int idx;
    idx = r * 4 + c;
    return hex ? 4'((idx + 1) % 16) : 4'(idx);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic clear_log();
    rx_a.delete();
    rx_b.delete();
    ovf_cnt  = 0;
    stab_err = 0;
  endtask

  task automatic keystroke(input int r, input int c, input int hold, input int gap);
    pressed = 16'(1) << (r * 4 + c);
    tick(hold);
    pressed = '0;
    tick(gap);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pressed = '0; key_ready = 1'b0;
    tick(3);
    vectors++; if (col_a !== 4'b1110) begin miscompares++; $display("FAIL reset_col_n got %b want 1110", col_a); end
    vectors++; if ({valid_a, held_a, ovf_a, code_a} !== 7'b0) begin miscompares++;
      $display("FAIL reset_outputs got v%b h%b o%b c%h want all 0", valid_a, held_a, ovf_a, code_a); end
    vectors++; if (col_b !== 4'b1110 || valid_b !== 1'b0) begin miscompares++;
      $display("FAIL reset_idx_dut got col %b valid %b want 1110 0", col_b, valid_b); end
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_single_key();
    clear_log();
    key_ready = 1'b1;
    pressed = 16'(1) << (1 * 4 + 2);
    tick(50);
    vectors++; if (held_a !== 1'b1) begin miscompares++; $display("FAIL t1_held got %b want 1", held_a); end
    pressed = '0;
    tick(30);
    vectors++; if (held_a !== 1'b0) begin miscompares++; $display("FAIL t1_release got %b want 0", held_a); end
    vectors++; if (rx_a.size() != 1) begin miscompares++; $display("FAIL t1_count got %0d want 1", rx_a.size()); end
    else begin
      vectors++; if (rx_a[0] !== legend(1, 2, 1)) begin miscompares++;
        $display("FAIL t1_code got %h want %h", rx_a[0], legend(1, 2, 1)); end
    end
  endtask

  task automatic test_legend();
    clear_log();
    key_ready = 1'b1;
    keystroke(3, 3, 50, 30);
    vectors++; if (rx_a.size() != 1 || rx_b.size() != 1) begin miscompares++;
      $display("FAIL t2_count got %0d/%0d want 1/1", rx_a.size(), rx_b.size()); end
    else begin
      vectors++; if (rx_a[0] !== 4'h0) begin miscompares++; $display("FAIL t2_hex got %h want 0", rx_a[0]); end
      vectors++; if (rx_b[0] !== 4'hF) begin miscompares++; $display("FAIL t2_idx got %h want f", rx_b[0]); end
    end
  endtask

  task automatic test_bounce();
    logic [15:0] m;
    clear_log();
    key_ready = 1'b1;
    m = 16'(1) << (0 * 4 + 1);
    for (int k = 0; k < 40; k++) begin pressed = ((k / 3) % 2 == 0) ? m : '0; tick(1); end
    pressed = m;
    tick(50);
    for (int k = 0; k < 40; k++) begin pressed = ((k / 3) % 2 == 0) ? '0 : m; tick(1); end
    pressed = '0;
    tick(30);
    vectors++; if (rx_a.size() != 1) begin miscompares++; $display("FAIL t3_count got %0d want 1", rx_a.size()); end
    else begin
      vectors++; if (rx_a[0] !== legend(0, 1, 1)) begin miscompares++;
        $display("FAIL t3_code got %h want %h", rx_a[0], legend(0, 1, 1)); end
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    key_ready = 1'b1;
    keystroke(2, 0, 40, 20);
    keystroke(3, 1, 40, 30);
    vectors++; if (rx_a.size() != 2 || rx_b.size() != 2) begin miscompares++;
      $display("FAIL b2b_count got %0d/%0d want 2/2", rx_a.size(), rx_b.size()); end
    else begin
      vectors++; if (rx_a[0] !== legend(2, 0, 1) || rx_a[1] !== legend(3, 1, 1)) begin miscompares++;
        $display("FAIL b2b_hex got %h %h want %h %h", rx_a[0], rx_a[1], legend(2, 0, 1), legend(3, 1, 1)); end
      vectors++; if (rx_b[0] !== legend(2, 0, 0) || rx_b[1] !== legend(3, 1, 0)) begin miscompares++;
        $display("FAIL b2b_idx got %h %h want %h %h", rx_b[0], rx_b[1], legend(2, 0, 0), legend(3, 1, 0)); end
    end
  endtask

  task automatic test_overflow();
    clear_log();
    key_ready = 1'b0;
    keystroke(0, 0, 50, 30);
    keystroke(2, 3, 50, 30);
    vectors++; if (valid_a !== 1'b1 || code_a !== legend(0, 0, 1)) begin miscompares++;
      $display("FAIL t4_slot got v%b c%h want v1 c%h", valid_a, code_a, legend(0, 0, 1)); end
    vectors++; if (ovf_cnt != 1) begin miscompares++; $display("FAIL t4_overflow got %0d pulses want 1", ovf_cnt); end
    vectors++; if (stab_err != 0) begin miscompares++; $display("FAIL t4_stable got %0d changes want 0", stab_err); end
    key_ready = 1'b1;
    tick(4);
    vectors++; if (rx_a.size() != 1 || valid_a !== 1'b0) begin miscompares++;
      $display("FAIL t4_drain got %0d codes valid %b want 1 0", rx_a.size(), valid_a); end
    else begin
      vectors++; if (rx_a[0] !== legend(0, 0, 1)) begin miscompares++;
        $display("FAIL t4_code got %h want %h", rx_a[0], legend(0, 0, 1)); end
    end
  endtask

  task automatic test_ghost();
    int mi, changes, dwell, bad_seq, bad_dwell;
    logic [3:0] prev;
    clear_log();
    key_ready = 1'b1;
    pressed = (16'(1) << (0 * 4 + 1)) | (16'(1) << (2 * 4 + 1));
    prev = col_a;
    mi = -1;
    for (int i = 0; i < 4; i++) if (!prev[i]) mi = i;
    changes = 0; dwell = 0; bad_seq = 0; bad_dwell = 0;
    for (int k = 0; k < 120; k++) begin
      tick(1);
      dwell++;
      if (col_a !== prev) begin
        mi = (mi + 1) % 4;
        if (col_a !== ~(4'(1) << mi)) bad_seq++;
        if (changes > 0 && dwell != S) bad_dwell++;
        changes++;
        dwell = 0;
        prev = col_a;
      end
    end
    vectors++; if (bad_seq != 0) begin miscompares++; $display("FAIL t5_sequence got %0d bad steps want 0", bad_seq); end
    vectors++; if (bad_dwell != 0) begin miscompares++; $display("FAIL t5_dwell got %0d bad dwells want 0", bad_dwell); end
    vectors++; if (changes < 25) begin miscompares++; $display("FAIL t5_cycling got %0d changes want >=25", changes); end
    vectors++; if (rx_a.size() != 0 || held_a !== 1'b0) begin miscompares++;
      $display("FAIL t5_no_key got %0d codes held %b want 0 0", rx_a.size(), held_a); end
    pressed = '0;
    tick(10);
  endtask

  task automatic test_random_keys();
    logic [3:0] exp_a[$];
    logic [3:0] exp_b[$];
    int r, c, errs;
    clear_log();
    for (int n = 0; n < 8; n++) begin
      r = int'($urandom_range(3, 0));
      c = int'($urandom_range(3, 0));
      exp_a.push_back(legend(r, c, 1));
      exp_b.push_back(legend(r, c, 0));
      pressed = 16'(1) << (r * 4 + c);
      repeat ($urandom_range(80, 45)) begin key_ready = 1'($urandom_range(1, 0)); tick(1); end
      pressed = '0;
      repeat ($urandom_range(50, 30)) begin key_ready = 1'($urandom_range(1, 0)); tick(1); end
    end
    key_ready = 1'b1;
    tick(10);
    vectors++; if (rx_a.size() != exp_a.size() || rx_b.size() != exp_b.size()) begin miscompares++;
      $display("FAIL rnd_count got %0d/%0d want %0d", rx_a.size(), rx_b.size(), exp_a.size()); end
    else begin
      errs = 0;
      for (int i = 0; i < exp_a.size(); i++)
        if (rx_a[i] !== exp_a[i] || rx_b[i] !== exp_b[i]) errs++;
      vectors++; if (errs != 0) begin miscompares++; $display("FAIL rnd_codes got %0d wrong codes want 0", errs); end
    end
    vectors++; if (ovf_cnt != 0 || stab_err != 0) begin miscompares++;
      $display("FAIL rnd_slot got ovf %0d unstable %0d want 0 0", ovf_cnt, stab_err); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    key_ready = 1'b0;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    pressed = 16'(1) << (1 * 4 + 2);
    tick(15);
    vectors++; if (col_a !== 4'b1011) begin miscompares++; $display("FAIL t6_col_before got %b want 1011", col_a); end
    #1 reset_n = 1'b0;
    #1;
    vectors++; if (col_a !== 4'b1110 || {valid_a, held_a, ovf_a, code_a} !== 7'b0) begin miscompares++;
      $display("FAIL t6_async_pressdb got col %b v%b h%b c%h want 1110 0 0 0", col_a, valid_a, held_a, code_a); end
    tick(1);
    reset_n = 1'b1;
    for (int k = 0; k < 80 && valid_a !== 1'b1; k++) tick(1);
    vectors++; if (valid_a !== 1'b1 || held_a !== 1'b1) begin miscompares++;
      $display("FAIL t6_pending got valid %b held %b want 1 1", valid_a, held_a); end
    #1 reset_n = 1'b0;
    #1;
    vectors++; if (col_a !== 4'b1110 || {valid_a, held_a, ovf_a, code_a} !== 7'b0) begin miscompares++;
      $display("FAIL t6_async_pending got col %b v%b h%b c%h want 1110 0 0 0", col_a, valid_a, held_a, code_a); end
    pressed = '0;
    tick(2);
    reset_n = 1'b1;
    key_ready = 1'b1;
    tick(40);
    vectors++; if (rx_a.size() != 0 || valid_a !== 1'b0) begin miscompares++;
      $display("FAIL t6_discard got %0d codes valid %b want 0 0", rx_a.size(), valid_a); end
  endtask

  initial begin
    reset_n = 1'b0;
    pressed = '0;
    key_ready = 1'b0;
    test_reset();
    test_single_key();
    test_legend();
    test_bounce();
    test_back_to_back();
    test_overflow();
    test_ghost();
    test_random_keys();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
